morse_round_ctrl: RTL

Round sequencer for the two-player morse game. Latches player1's committed code, hands the board to player2, and reloads player2's comparator at the start of each guess phase. Enforces an attempt limit and a guess time limit, keeps per-player scores over a fixed number of rounds, and exposes phase and score state to the display logic.

---
 rtl/morse_pkg.sv | 25 ++
 rtl/round_timer.sv | 30 +++
 rtl/morse_round_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared constants for the two-player morse game: symbol codes, player2
// per-symbol result codes and the round controller's state encoding.
package morse_pkg;

    localparam logic [1:0] MORSE_NONE = 2'b00;
    localparam logic [1:0] MORSE_DOT  = 2'b01;
    localparam logic [1:0] MORSE_LINE = 2'b10;

    localparam logic [1:0] NEUTRAL   = 2'b00;
    localparam logic [1:0] CORRECT   = 2'b01;
    localparam logic [1:0] INCORRECT = 2'b10;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_P1_ENTRY = 3'd1;
    localparam logic [2:0] ST_P2_GUESS = 3'd2;
    localparam logic [2:0] ST_WIN      = 3'd3;
    localparam logic [2:0] ST_LOSE     = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Scores stop at 7 so a long game can never wrap back to a low count.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter shared by the guess and result phases; expire is
// high for the single cycle in which an enabled count sits at zero.
module round_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Combinational so the controller can act on expiry in the same cycle;
    // it must not depend on load, which is itself derived from expire.
    assign expire = en && (count == '0);

endmodule

// File: rtl/morse_round_ctrl.sv
// Round sequencer for the two-player morse game: code commit, guess phase
// with attempt and time limits, result dwell, scoring and round counting.
module morse_round_ctrl
    import morse_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int RESULT_CYCLES  = 25_000_000,
    parameter int NUM_ROUNDS     = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       p1_done,
    input  logic [9:0] p1_value,
    input  logic [1:0] p2_correct,
    input  logic       p2_complete,
    output logic       p1_en,
    output logic       p2_en,
    output logic       p2_next_n,
    output logic [9:0] code_q,
    output logic [1:0] attempts_left,
    output logic [2:0] score_p1,
    output logic [2:0] score_p2,
    output logic [2:0] round_q,
    output logic [2:0] phase,
    output logic       game_over
);

    // One timer serves both phases, so it is sized for the longer interval.
    localparam int TW_GUESS  = $clog2(TIMEOUT_CYCLES);
    localparam int TW_RESULT = $clog2(RESULT_CYCLES);
    localparam int TW_MAX    = (TW_GUESS > TW_RESULT) ? TW_GUESS : TW_RESULT;
    localparam int TW        = (TW_MAX < 1) ? 1 : TW_MAX;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic          start_q;
    logic          start_edge;
    logic          accept;
    logic          win;
    logic          lose;
    logic          att_dec;
    logic          att_zero;
    logic          result_done;
    logic          new_game;
    logic          timer_load;
    logic          timer_en;
    logic          expire;
    logic [TW-1:0] timer_value;

    assign start_edge = start && !start_q;
    assign phase      = state;

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        win         = 1'b0;
        lose        = 1'b0;
        att_dec     = 1'b0;
        att_zero    = 1'b0;
        result_done = 1'b0;
        new_game    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    next_state = ST_P1_ENTRY;
                    new_game   = 1'b1;
                end
            end
            ST_P1_ENTRY: begin
                if (p1_done && (p1_value != '0)) begin
                    next_state = ST_P2_GUESS;
                    accept     = 1'b1;
                end
            end
            ST_P2_GUESS: begin
                if (p2_complete) begin
                    next_state = ST_WIN;
                    win        = 1'b1;
                end else if (expire) begin
                    next_state = ST_LOSE;
                    lose       = 1'b1;
                end else if (p2_correct == INCORRECT) begin
                    if (attempts_left == 2'd1) begin
                        next_state = ST_LOSE;
                        lose       = 1'b1;
                        att_zero   = 1'b1;
                    end else begin
                        att_dec = 1'b1;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (expire) begin
                    result_done = 1'b1;
                    next_state  = (round_q == 3'(NUM_ROUNDS)) ? ST_DONE : ST_P1_ENTRY;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign timer_load  = accept || win || lose;
    assign timer_value = accept ? TW'(TIMEOUT_CYCLES - 1) : TW'(RESULT_CYCLES - 1);
    assign timer_en    = (state == ST_P2_GUESS) || (state == ST_WIN) || (state == ST_LOSE);

    round_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clock (clock),
        .resetn(resetn),
        .load  (timer_load),
        .value (timer_value),
        .en    (timer_en),
        .expire(expire)
    );

    // Enables are computed from the next state so they line up with phase;
    // p2_en additionally waits out the single reload cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            start_q       <= 1'b0;
            p1_en         <= 1'b0;
            p2_en         <= 1'b0;
            p2_next_n     <= 1'b1;
            game_over     <= 1'b0;
            code_q        <= '0;
            attempts_left <= '0;
            score_p1      <= '0;
            score_p2      <= '0;
            round_q       <= '0;
        end else begin
            state     <= next_state;
            start_q   <= start;
            p1_en     <= (next_state == ST_P1_ENTRY);
            p2_en     <= (state == ST_P2_GUESS) && (next_state == ST_P2_GUESS);
            p2_next_n <= !accept;
            game_over <= (next_state == ST_DONE);

            if (accept) begin
                code_q        <= p1_value;
                attempts_left <= 2'(MAX_ATTEMPTS);
            end else if (att_zero) begin
                attempts_left <= '0;
            end else if (att_dec) begin
                attempts_left <= attempts_left - 2'd1;
            end

            if (new_game) begin
                score_p1 <= '0;
                score_p2 <= '0;
                round_q  <= 3'd1;
            end else begin
                if (win) begin
                    score_p2 <= sat_inc(score_p2);
                end
                if (lose) begin
                    score_p1 <= sat_inc(score_p1);
                end
                if (result_done && (next_state == ST_P1_ENTRY)) begin
                    round_q <= round_q + 3'd1;
                end
            end
        end
    end

endmodule
